// File: rtl/capture_trig_ctrl.sv
// capture_trig_ctrl: capture/trigger controller for the logic analyser sampling path.
// It writes the pre-trigger samples, keeps a ring of pre_samples while armed,
// raises trig_stb on the trigger sample, counts the post-trigger samples and then stops.
// The strobes tell the downstream FIFO when to write and when to drop its oldest
// entry, so the FIFO ends up holding exactly pre+post samples around the trigger.
// Optional build macro CAPTURE_TRIG_OCCUR_EN adds the trig_occur port. The trigger
// then fires on the (trig_occur+1)-th qualifying sample instead of the first one.
module capture_trig_ctrl #(
  parameter int CH_NUM   = 16,
  parameter int CNT_W    = 24,
  parameter int CH_SEL_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CH_NUM-1:0]   data_in,
  input  logic                samp_stb,
  input  logic                start_stb,
  input  logic                abort_stb,
  input  logic [2:0]          trig_mode,
  input  logic [CH_SEL_W-1:0] trig_ch,
  input  logic [CH_NUM-1:0]   trig_mask,
  input  logic [CH_NUM-1:0]   trig_pattern,
  input  logic [CNT_W-1:0]    pre_samples,
  input  logic [CNT_W-1:0]    post_samples,
`ifdef CAPTURE_TRIG_OCCUR_EN
  input  logic [7:0]          trig_occur,
`endif
  output logic [CH_NUM-1:0]   data_out,
  output logic                wr_stb,
  output logic                discard_stb,
  output logic                trig_stb,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {S_IDLE, S_PRETRIG, S_ARMED, S_POST, S_DONE} state_t;

  localparam logic [CH_SEL_W:0] CH_LIM = (CH_SEL_W+1)'(CH_NUM);

  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [CH_SEL_W-1:0] ch_q, ch_d;
  logic [CH_NUM-1:0]   mask_q, mask_d, pat_q, pat_d;
  logic [CNT_W-1:0]    pre_q, pre_d, post_q, post_d;
  logic [CNT_W-1:0]    pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic [CH_NUM-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [CH_NUM-1:0]   data_out_q, data_out_d;
  logic                wr_q, wr_d, disc_q, disc_d, trig_q, trig_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                hit, fire, cur_bit, prv_bit;
  logic [CNT_W-1:0]    pre_cnt_inc, post_cnt_inc;
`ifdef CAPTURE_TRIG_OCCUR_EN
  logic [7:0]          occur_q, occur_d, hit_cnt_q, hit_cnt_d;
`endif

  // Counts never pass their latched limits, so the increment cannot wrap.
  assign pre_cnt_inc  = pre_cnt_q + CNT_W'(1);
  assign post_cnt_inc = post_cnt_q + CNT_W'(1);
  assign cur_bit      = data_in[ch_q];
  assign prv_bit      = prev_q[ch_q];

  // Trigger condition for the current sample against the latched config.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      3'd1:    hit = prev_vld_q & ~prv_bit & cur_bit;
      3'd2:    hit = prev_vld_q & prv_bit & ~cur_bit;
      3'd3:    hit = prev_vld_q & (prv_bit ^ cur_bit);
      3'd4:    hit = cur_bit;
      3'd5:    hit = ~cur_bit;
      3'd6:    hit = ((data_in ^ pat_q) & mask_q) == '0;
      default: hit = 1'b1;
    endcase
`ifdef CAPTURE_TRIG_OCCUR_EN
    fire = hit && (hit_cnt_q == occur_q);
`else
    fire = hit;
`endif
  end

  // Next state, counters, config latch and registered strobes.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    pat_d      = pat_q;
    pre_d      = pre_q;
    post_d     = post_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    data_out_d = data_out_q;
    wr_d       = 1'b0;
    disc_d     = 1'b0;
    trig_d     = 1'b0;
`ifdef CAPTURE_TRIG_OCCUR_EN
    occur_d    = occur_q;
    hit_cnt_d  = hit_cnt_q;
`endif
    if (abort_stb) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start_stb) begin
          mode_d     = trig_mode;
          ch_d       = ({1'b0, trig_ch} >= CH_LIM) ? '0 : trig_ch;
          mask_d     = trig_mask;
          pat_d      = trig_pattern;
          pre_d      = pre_samples;
          post_d     = (post_samples == '0) ? CNT_W'(1) : post_samples;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          prev_vld_d = 1'b0;
`ifdef CAPTURE_TRIG_OCCUR_EN
          occur_d    = trig_occur;
          hit_cnt_d  = '0;
`endif
          state_d    = (pre_samples == '0) ? S_ARMED : S_PRETRIG;
        end
        S_PRETRIG: if (samp_stb) begin
          wr_d      = 1'b1;
          pre_cnt_d = pre_cnt_inc;
          if (pre_cnt_inc == pre_q) state_d = S_ARMED;
        end
        S_ARMED: if (samp_stb) begin
          wr_d = 1'b1;
          if (fire) begin
            trig_d     = 1'b1;
            post_cnt_d = CNT_W'(1);
            state_d    = (post_q == CNT_W'(1)) ? S_DONE : S_POST;
          end else begin
            disc_d = 1'b1;
`ifdef CAPTURE_TRIG_OCCUR_EN
            if (hit) hit_cnt_d = hit_cnt_q + 8'd1;
`endif
          end
        end
        S_POST: if (samp_stb) begin
          wr_d       = 1'b1;
          post_cnt_d = post_cnt_inc;
          if (post_cnt_inc == post_q) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
      // Any sample taken while busy becomes the reference for edge modes.
      if (samp_stb && (state_q == S_PRETRIG || state_q == S_ARMED || state_q == S_POST)) begin
        prev_d     = data_in;
        prev_vld_d = 1'b1;
        data_out_d = data_in;
      end
    end
    busy_d = (state_d == S_PRETRIG) || (state_d == S_ARMED) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      pat_q      <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      data_out_q <= '0;
      wr_q       <= 1'b0;
      disc_q     <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CAPTURE_TRIG_OCCUR_EN
      occur_q    <= '0;
      hit_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      pat_q      <= pat_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      data_out_q <= data_out_d;
      wr_q       <= wr_d;
      disc_q     <= disc_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CAPTURE_TRIG_OCCUR_EN
      occur_q    <= occur_d;
      hit_cnt_q  <= hit_cnt_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign wr_stb      = wr_q;
  assign discard_stb = disc_q;
  assign trig_stb    = trig_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_capture_trig_ctrl.sv
// Testbench for capture_trig_ctrl: directed scenarios plus randomized captures.
// Expectations come from a sample-index model: it finds the trigger sample index
// in the stimulus list and classifies every sample by its position relative to it.
module tb_capture_trig_ctrl;
  localparam int CH = 16;
  localparam int CW = 24;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [CH-1:0] data_in;
  logic          samp_stb, start_stb, abort_stb;
  logic [2:0]    trig_mode;
  logic [SW-1:0] trig_ch;
  logic [CH-1:0] trig_mask, trig_pattern;
  logic [CW-1:0] pre_samples, post_samples;
  logic [7:0]    trig_occur;
  logic [CH-1:0] data_out;
  logic          wr_stb, discard_stb, trig_stb, busy, done;

  int n_chk = 0;
  int n_pass = 0;

  // Model configuration and the sample stream of the current capture.
  int cfg_mode, cfg_ch, cfg_pre, cfg_post, cfg_occ;
  logic [CH-1:0] cfg_mask, cfg_pat;
  logic [CH-1:0] smp[$];

  always #5 CLK = ~CLK;

  capture_trig_ctrl #(.CH_NUM(CH), .CNT_W(CW), .CH_SEL_W(SW)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .samp_stb(samp_stb),
    .start_stb(start_stb), .abort_stb(abort_stb), .trig_mode(trig_mode),
    .trig_ch(trig_ch), .trig_mask(trig_mask), .trig_pattern(trig_pattern),
    .pre_samples(pre_samples), .post_samples(post_samples),
`ifdef CAPTURE_TRIG_OCCUR_EN
    .trig_occur(trig_occur),
`endif
    .data_out(data_out), .wr_stb(wr_stb), .discard_stb(discard_stb),
    .trig_stb(trig_stb), .busy(busy), .done(done)
  );

  function automatic bit hit_at(int j);
    int m, c;
    logic [CH-1:0] s, p;
    bit hp;
    m  = (cfg_mode == 7) ? 0 : cfg_mode;
    c  = (cfg_ch >= CH) ? 0 : cfg_ch;
    s  = smp[j];
    hp = (j > 0);
    p  = hp ? smp[j-1] : '0;
    case (m)
      1: return hp && !p[c] && s[c];
      2: return hp && p[c] && !s[c];
      3: return hp && (p[c] != s[c]);
      4: return s[c];
      5: return !s[c];
      6: return (s & cfg_mask) == (cfg_pat & cfg_mask);
      default: return 1'b1;
    endcase
  endfunction

  // Index of the triggering sample, or -1 if the stream never triggers.
  function automatic int find_trig();
    int hits = 0;
    for (int j = cfg_pre; j < smp.size(); j++)
      if (hit_at(j)) begin
        if (hits == cfg_occ) return j;
        hits++;
      end
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive_cfg();
    trig_mode    = 3'(cfg_mode);
    trig_ch      = SW'(cfg_ch);
    trig_mask    = cfg_mask;
    trig_pattern = cfg_pat;
    pre_samples  = CW'(cfg_pre);
    post_samples = CW'(cfg_post);
    trig_occur   = 8'(cfg_occ);
  endtask

  // Runs one capture of smp[0..nsamp-1] from IDLE/DONE, checking every cycle.
  task automatic run_capture(input int nsamp, input bit dense, output int obs_t);
    int t, post_e, last, i, cyc;
    bit s, ew, ed, et, edone, ok;
    logic [CH-1:0] fifo[$];
    t      = find_trig();
    post_e = (cfg_post == 0) ? 1 : cfg_post;
    last   = (t >= 0) ? t + post_e - 1 : -1;
    obs_t  = -1;
    drive_cfg();
    start_stb = 1'b1; abort_stb = 1'b0;
    samp_stb  = 1'($urandom_range(0, 1));
    data_in   = CH'($urandom);
    tick();
    n_chk++;
    if (busy !== 1'b1 || wr_stb !== 1'b0 || done !== 1'b0)
      $display("FAIL start: busy=%b wr=%b done=%b, want 1 0 0", busy, wr_stb, done);
    else n_pass++;
    i = 0; cyc = 0;
    while (i < nsamp && cyc < 4 * nsamp + 20) begin
      edone = (last >= 0) && (i > last);
      s = dense || ($urandom_range(0, 3) != 0);
      samp_stb     = s;
      data_in      = s ? smp[i] : CH'($urandom);
      trig_mode    = 3'($urandom);
      trig_ch      = SW'($urandom);
      trig_mask    = CH'($urandom);
      trig_pattern = CH'($urandom);
      pre_samples  = CW'($urandom_range(0, 7));
      post_samples = CW'($urandom_range(0, 7));
      trig_occur   = 8'($urandom_range(0, 3));
      start_stb    = !edone && ($urandom_range(0, 7) == 0);
      tick(); cyc++;
      ew = 0; ed = 0; et = 0;
      if (s) begin
        if (t < 0) begin
          ew = 1; ed = (i >= cfg_pre);
        end else if (i <= last) begin
          ew = 1; ed = (i >= cfg_pre) && (i < t); et = (i == t);
        end
      end
      n_chk++;
      if ({wr_stb, discard_stb, trig_stb} !== {ew, ed, et} || (ew && data_out !== smp[i]))
        $display("FAIL strobes i=%0d: wr/disc/trig=%b%b%b data=%h, want %b%b%b data=%h",
                 i, wr_stb, discard_stb, trig_stb, data_out, ew, ed, et, s ? smp[i] : '0);
      else n_pass++;
      if (wr_stb === 1'b1) begin
        fifo.push_back(data_out);
        if (discard_stb === 1'b1) void'(fifo.pop_front());
      end
      if (trig_stb === 1'b1 && obs_t < 0) obs_t = i;
      if (s) i++;
      edone = (last >= 0) && (i > last);
      n_chk++;
      if (done !== edone || busy !== !edone)
        $display("FAIL status i=%0d: done=%b busy=%b, want %b %b", i, done, busy, edone, !edone);
      else n_pass++;
    end
    start_stb = 1'b0; samp_stb = 1'b0;
    if (i < nsamp) begin
      n_chk++;
      $display("FAIL timeout: fed %0d samples, want %0d", i, nsamp);
    end
    if (last >= 0 && last < nsamp) begin
      ok = (fifo.size() == cfg_pre + post_e);
      for (int k = 0; ok && k < fifo.size(); k++) ok = (fifo[k] === smp[t - cfg_pre + k]);
      n_chk++;
      if (!ok) $display("FAIL buffer: size=%0d, want %0d starting at sample %0d",
                        fifo.size(), cfg_pre + post_e, t - cfg_pre);
      else n_pass++;
    end else begin
      abort_stb = 1'b1;
      tick();
      abort_stb = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL abort_end: busy=%b done=%b, want 0 0", busy, done);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; samp_stb = 1'b1; start_stb = 1'b1; abort_stb = 1'b0;
    data_in = 16'hFFFF; cfg_mode = 0; cfg_ch = 0; cfg_pre = 0; cfg_post = 1; cfg_occ = 0;
    cfg_mask = '0; cfg_pat = '0; drive_cfg();
    tick(); tick();
    n_chk++;
    if ({wr_stb, discard_stb, trig_stb, busy, done} !== 5'b0 || data_out !== '0)
      $display("FAIL reset: outs=%b data=%h, want 0", {wr_stb, discard_stb, trig_stb, busy, done}, data_out);
    else n_pass++;
    RST = 1'b0; samp_stb = 1'b0; start_stb = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    int ot;
    cfg_mode = 0; cfg_ch = 0; cfg_pre = 4; cfg_post = 3; cfg_occ = 0; cfg_mask = '0; cfg_pat = '0;
    smp.delete();
    for (int k = 0; k < 10; k++) smp.push_back(CH'($urandom));
    run_capture(10, 1'b1, ot);
    n_chk++;
    if (ot !== 4) $display("FAIL immediate_trig: at sample %0d, want 4", ot);
    else n_pass++;
  endtask

  task automatic test_rise();
    int ot;
    cfg_mode = 1; cfg_ch = 3; cfg_pre = 2; cfg_post = 2; cfg_occ = 0; cfg_mask = '0; cfg_pat = '0;
    smp.delete();
    for (int k = 0; k < 6; k++) smp.push_back(CH'($urandom) & ~16'h0008);
    smp.push_back(CH'($urandom) | 16'h0008);
    for (int k = 0; k < 3; k++) smp.push_back(CH'($urandom));
    run_capture(10, 1'b1, ot);
    n_chk++;
    if (ot !== 6) $display("FAIL rise_trig: at sample %0d, want 6", ot);
    else n_pass++;
  endtask

  task automatic test_pattern();
    int ot;
    cfg_mode = 6; cfg_ch = 0; cfg_pre = 0; cfg_post = 2; cfg_occ = 0;
    cfg_mask = 16'h00F0; cfg_pat = 16'h0050;
    smp.delete();
    smp.push_back(16'h0A40); smp.push_back(16'h1256);
    for (int k = 0; k < 3; k++) smp.push_back(CH'($urandom));
    run_capture(5, 1'b0, ot);
    n_chk++;
    if (ot !== 1) $display("FAIL pattern_trig: at sample %0d, want 1", ot);
    else n_pass++;
  endtask

  task automatic test_abort();
    cfg_mode = 4; cfg_ch = 0; cfg_pre = 1; cfg_post = 2; cfg_occ = 0; cfg_mask = '0; cfg_pat = '0;
    drive_cfg(); start_stb = 1'b1; samp_stb = 1'b0; tick();
    start_stb = 1'b0; samp_stb = 1'b1; data_in = 16'h0002; tick();
    samp_stb = 1'b1; data_in = 16'h0000; tick();
    n_chk++;
    if ({wr_stb, discard_stb, trig_stb, busy} !== 4'b1101)
      $display("FAIL armed_ring: wr/disc/trig/busy=%b, want 1101", {wr_stb, discard_stb, trig_stb, busy});
    else n_pass++;
    abort_stb = 1'b1; start_stb = 1'b1; data_in = 16'h0001; tick();
    abort_stb = 1'b0; start_stb = 1'b0;
    n_chk++;
    if ({wr_stb, trig_stb, busy, done} !== 4'b0000)
      $display("FAIL abort_start: wr/trig/busy/done=%b, want 0000", {wr_stb, trig_stb, busy, done});
    else n_pass++;
    tick();
    n_chk++;
    if (wr_stb !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_samp: wr=%b busy=%b, want 0 0", wr_stb, busy);
    else n_pass++;
    // A start pulse in POST must not disturb the running capture.
    cfg_mode = 0; cfg_pre = 0; cfg_post = 3; drive_cfg();
    start_stb = 1'b1; samp_stb = 1'b0; tick();
    start_stb = 1'b0; samp_stb = 1'b1; data_in = 16'hA5A5; tick();
    n_chk++;
    if ({wr_stb, trig_stb} !== 2'b11) $display("FAIL post_first: wr/trig=%b, want 11", {wr_stb, trig_stb});
    else n_pass++;
    start_stb = 1'b1; pre_samples = 24'd2; trig_mode = 3'd4; data_in = 16'h5A5A; tick();
    start_stb = 1'b0;
    n_chk++;
    if ({wr_stb, discard_stb, trig_stb, busy, done} !== 5'b10010 || data_out !== 16'h5A5A)
      $display("FAIL post_start: outs=%b data=%h, want 10010 5a5a",
               {wr_stb, discard_stb, trig_stb, busy, done}, data_out);
    else n_pass++;
    data_in = 16'h1234; tick();
    n_chk++;
    if ({wr_stb, busy, done} !== 3'b101) $display("FAIL post_done: wr/busy/done=%b, want 101", {wr_stb, busy, done});
    else n_pass++;
    tick();
    n_chk++;
    if (wr_stb !== 1'b0 || done !== 1'b1) $display("FAIL done_samp: wr=%b done=%b, want 0 1", wr_stb, done);
    else n_pass++;
    samp_stb = 1'b0;
  endtask

  task automatic test_reset_mid_post();
    bit bad;
    cfg_mode = 0; cfg_ch = 0; cfg_pre = 1; cfg_post = 10; cfg_occ = 0; drive_cfg();
    start_stb = 1'b1; samp_stb = 1'b0; tick();
    start_stb = 1'b0; samp_stb = 1'b1;
    for (int k = 0; k < 3; k++) begin data_in = CH'($urandom) | 16'h0001; tick(); end
    RST = 1'b1; tick();
    n_chk++;
    if ({wr_stb, discard_stb, trig_stb, busy, done} !== 5'b0 || data_out !== '0)
      $display("FAIL rst_post: outs=%b data=%h, want 0", {wr_stb, discard_stb, trig_stb, busy, done}, data_out);
    else n_pass++;
    tick(); tick();
    RST = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (wr_stb !== 1'b0 || busy !== 1'b0) bad = 1; end
    n_chk++;
    if (bad) $display("FAIL rst_after: wr=%b busy=%b, want 0 0", wr_stb, busy);
    else n_pass++;
    samp_stb = 1'b0;
  endtask

`ifdef CAPTURE_TRIG_OCCUR_EN
  task automatic test_occur();
    int ot;
    cfg_mode = 4; cfg_ch = 0; cfg_pre = 0; cfg_post = 1; cfg_occ = 2; cfg_mask = '0; cfg_pat = '0;
    smp.delete();
    smp.push_back(16'h0001); smp.push_back(16'h0003); smp.push_back(16'h0005);
    smp.push_back(CH'($urandom)); smp.push_back(CH'($urandom));
    run_capture(5, 1'b1, ot);
    n_chk++;
    if (ot !== 2) $display("FAIL occur_trig: at sample %0d, want 2", ot);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int ot;
    for (int it = 0; it < 25; it++) begin
      cfg_mode = $urandom_range(0, 7);
      cfg_ch   = $urandom_range(0, CH - 1);
      cfg_mask = CH'($urandom) & CH'($urandom) & CH'($urandom);
      cfg_pat  = CH'($urandom);
      cfg_pre  = $urandom_range(0, 5);
      cfg_post = $urandom_range(0, 5);
`ifdef CAPTURE_TRIG_OCCUR_EN
      cfg_occ  = $urandom_range(0, 2);
`else
      cfg_occ  = 0;
`endif
      smp.delete();
      for (int k = 0; k < 30; k++) smp.push_back(CH'($urandom));
      run_capture(30, 1'b0, ot);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_rise();
    test_pattern();
    test_abort();
    test_reset_mid_post();
`ifdef CAPTURE_TRIG_OCCUR_EN
    test_occur();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
